// File: rtl/branch_predictor_btb_pkg.sv
// Shared processor package: ALU opcodes plus the branch-predictor counter
// encodings and the 2-bit saturating update function.
package branch_predictor_btb_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA
    } alu_op_e;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } bp_cnt_e;

    // Jumps are always taken, so they pin the counter to strong-taken.
    function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt,
                                                input logic       taken,
                                                input logic       jump);
        logic [1:0] nxt;
        nxt = cnt;
        if (jump)
            nxt = CNT_ST;
        else if (taken)
            nxt = (cnt == CNT_ST)  ? cnt : cnt + 2'b01;
        else
            nxt = (cnt == CNT_SNT) ? cnt : cnt - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter2.sv
// Per-entry 2-bit saturating counter next-state logic.
module sat_counter2
    import branch_predictor_btb_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    input  logic       jump,
    output logic [1:0] cnt_next
);

    assign cnt_next = sat_cnt_next(cnt, taken, jump);

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped flop-based BTB with 2-bit counters, combinational lookup,
// EX-stage misprediction detection and saturating statistics.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int BTB_DEPTH  = 16,
    parameter int PC_STEP    = 1,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PC_WIDTH-1:0]   PC_F,
    output logic                  pred_taken_F,
    output logic [PC_WIDTH-1:0]   pred_target_F,
    input  logic                  update_valid_E,
    input  logic [PC_WIDTH-1:0]   update_pc_E,
    input  logic                  update_jump_E,
    input  logic                  update_taken_E,
    input  logic [PC_WIDTH-1:0]   update_target_E,
    input  logic                  pred_taken_E,
    input  logic [PC_WIDTH-1:0]   pred_target_E,
    input  logic                  btb_clear,
    output logic                  mispredict_E,
    output logic [PC_WIDTH-1:0]   redirect_pc_E,
    output logic [STAT_WIDTH-1:0] lookup_cnt,
    output logic [STAT_WIDTH-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_WIDTH - IDX_W;

    logic [BTB_DEPTH-1:0]               valid_q;
    logic [BTB_DEPTH-1:0][TAG_W-1:0]    tag_q;
    logic [BTB_DEPTH-1:0][PC_WIDTH-1:0] tgt_q;
    logic [BTB_DEPTH-1:0][1:0]          cnt_q;
    logic [BTB_DEPTH-1:0][1:0]          cnt_nxt;

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             rd_hit;
    logic             upd_hit;

    assign rd_idx  = PC_F[IDX_W-1:0];
    assign rd_tag  = PC_F[PC_WIDTH-1:IDX_W];
    assign upd_idx = update_pc_E[IDX_W-1:0];
    assign upd_tag = update_pc_E[PC_WIDTH-1:IDX_W];

    // Reads see the flop outputs, so a same-cycle update is only visible next cycle.
    assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken_F  = rd_hit && cnt_q[rd_idx][1];
    assign pred_target_F = tgt_q[rd_idx];

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign mispredict_E  = update_valid_E &&
                           ((pred_taken_E != update_taken_E) ||
                            (update_taken_E && (pred_target_E != update_target_E)));
    assign redirect_pc_E = update_taken_E ? update_target_E
                                          : update_pc_E + PC_WIDTH'(PC_STEP);

    for (genvar i = 0; i < BTB_DEPTH; i++) begin : g_entry
        logic                v_q;
        logic [TAG_W-1:0]    t_q;
        logic [PC_WIDTH-1:0] tg_q;
        logic [1:0]          c_q;
        logic                sel;

        assign sel = update_valid_E && (upd_idx == IDX_W'(i));

        sat_counter2 u_cnt (
            .cnt      (c_q),
            .taken    (update_taken_E),
            .jump     (update_jump_E),
            .cnt_next (cnt_nxt[i])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                t_q  <= '0;
                tg_q <= '0;
                c_q  <= CNT_WNT;
            end else if (btb_clear) begin
                v_q <= 1'b0;
            end else if (sel) begin
                if (upd_hit) begin
                    c_q <= cnt_nxt[i];
                    if (update_taken_E)
                        tg_q <= update_target_E;
                end else if (update_taken_E) begin
                    // Allocation evicts whatever aliased into this slot.
                    v_q  <= 1'b1;
                    t_q  <= upd_tag;
                    tg_q <= update_target_E;
                    c_q  <= update_jump_E ? CNT_ST : CNT_WT;
                end
            end
        end

        assign valid_q[i] = v_q;
        assign tag_q[i]   = t_q;
        assign tgt_q[i]   = tg_q;
        assign cnt_q[i]   = c_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (lookup_cnt != '1)
                lookup_cnt <= lookup_cnt + 1'b1;
            if (mispredict_E && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed vector table plus randomized traffic against a PC-keyed table model.
module tb_branch_predictor_btb;

    localparam int PW = 32;
    localparam int D  = 16;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] PC_F;
    logic          pred_taken_F;
    logic [PW-1:0] pred_target_F;
    logic          update_valid_E;
    logic [PW-1:0] update_pc_E;
    logic          update_jump_E;
    logic          update_taken_E;
    logic [PW-1:0] update_target_E;
    logic          pred_taken_E;
    logic [PW-1:0] pred_target_E;
    logic          btb_clear;
    logic          mispredict_E;
    logic [PW-1:0] redirect_pc_E;
    logic [SW-1:0] lookup_cnt;
    logic [SW-1:0] mispredict_cnt;

    branch_predictor_btb #(.PC_WIDTH(PW), .BTB_DEPTH(D), .PC_STEP(1), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .PC_F(PC_F),
        .pred_taken_F(pred_taken_F), .pred_target_F(pred_target_F),
        .update_valid_E(update_valid_E), .update_pc_E(update_pc_E),
        .update_jump_E(update_jump_E), .update_taken_E(update_taken_E),
        .update_target_E(update_target_E), .pred_taken_E(pred_taken_E),
        .pred_target_E(pred_target_E), .btb_clear(btb_clear),
        .mispredict_E(mispredict_E), .redirect_pc_E(redirect_pc_E),
        .lookup_cnt(lookup_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pc_f;
        logic          uv;
        logic [PW-1:0] upc;
        logic          uj;
        logic          ut;
        logic [PW-1:0] utgt;
        logic          pte;
        logic [PW-1:0] ptt;
        logic          clr;
        logic          e_tk;
        logic [PW-1:0] e_tg;
        logic          e_mis;
        logic [PW-1:0] e_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Model keeps the full PC of each occupant instead of a split tag.
    bit            mv  [D];
    logic [PW-1:0] mpc [D];
    logic [PW-1:0] mtgt[D];
    int            mcnt[D];
    int            mlook;
    int            mmis;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t up(input logic [PW-1:0] pc_f, input logic uv,
                                input logic [PW-1:0] upc, input logic uj, input logic ut,
                                input logic [PW-1:0] utgt, input logic pte,
                                input logic [PW-1:0] ptt, input logic clr, input logic e_tk,
                                input logic [PW-1:0] e_tg, input logic e_mis,
                                input logic [PW-1:0] e_rd);
        vec_t v;
        v.pc_f = pc_f; v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut; v.utgt = utgt;
        v.pte = pte; v.ptt = ptt; v.clr = clr;
        v.e_tk = e_tk; v.e_tg = e_tg; v.e_mis = e_mis; v.e_rd = e_rd;
        return v;
    endfunction

    function automatic vec_t nu(input logic [PW-1:0] pc_f, input logic e_tk,
                                input logic [PW-1:0] e_tg);
        return up(pc_f, 0, 0, 0, 0, 0, 0, 0, 0, e_tk, e_tg, 0, 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            mv[i] = 0; mcnt[i] = 1; mpc[i] = '0; mtgt[i] = '0;
        end
        mlook = 0;
        mmis  = 0;
    endtask

    task automatic model_pred(input logic [PW-1:0] pc, output logic tk, output logic [PW-1:0] tg);
        int idx;
        idx = int'(pc % D);
        tk  = mv[idx] && (mpc[idx] == pc) && (mcnt[idx] >= 2);
        tg  = mtgt[idx];
    endtask

    function automatic logic model_mis(input vec_t v);
        return v.uv && ((v.pte != v.ut) || (v.ut && (v.ptt != v.utgt)));
    endfunction

    function automatic logic [PW-1:0] model_rd(input vec_t v);
        logic [PW-1:0] nxt;
        nxt = v.upc + 1;
        return v.ut ? v.utgt : nxt;
    endfunction

    task automatic model_edge(input vec_t v);
        int idx;
        idx = int'(v.upc % D);
        if (mlook < 255) mlook++;
        if (model_mis(v) && mmis < 255) mmis++;
        if (v.clr) begin
            for (int i = 0; i < D; i++) mv[i] = 0;
        end else if (v.uv) begin
            if (mv[idx] && mpc[idx] == v.upc) begin
                if (v.uj)       mcnt[idx] = 3;
                else if (v.ut)  mcnt[idx] = (mcnt[idx] == 3) ? 3 : mcnt[idx] + 1;
                else            mcnt[idx] = (mcnt[idx] == 0) ? 0 : mcnt[idx] - 1;
                if (v.ut) mtgt[idx] = v.utgt;
            end else if (v.ut) begin
                mv[idx] = 1; mpc[idx] = v.upc; mtgt[idx] = v.utgt;
                mcnt[idx] = v.uj ? 3 : 2;
            end
        end
    endtask

    task automatic apply(input vec_t v);
        PC_F = v.pc_f; update_valid_E = v.uv; update_pc_E = v.upc;
        update_jump_E = v.uj; update_taken_E = v.ut; update_target_E = v.utgt;
        pred_taken_E = v.pte; pred_target_E = v.ptt; btb_clear = v.clr;
    endtask

    // One cycle: drive, check combinational outputs and stats, advance model and clock.
    task automatic step(input vec_t v, input bit use_tbl, input string nm);
        logic          tk;
        logic [PW-1:0] tg;
        apply(v);
        #1;
        if (use_tbl) begin
            tk = v.e_tk; tg = v.e_tg;
            chk({nm, ".mis"}, mispredict_E, v.e_mis);
            chk({nm, ".redir"}, redirect_pc_E, v.e_rd);
        end else begin
            model_pred(v.pc_f, tk, tg);
            chk({nm, ".mis"}, mispredict_E, model_mis(v));
            chk({nm, ".redir"}, redirect_pc_E, model_rd(v));
        end
        chk({nm, ".taken_F"}, pred_taken_F, tk);
        if (tk) chk({nm, ".target_F"}, pred_target_F, tg);
        chk({nm, ".lookup_cnt"}, lookup_cnt, mlook);
        chk({nm, ".mispredict_cnt"}, mispredict_cnt, mmis);
        model_edge(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        vecs.push_back(up(32'h10, 1, 32'h10, 0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h40));
        vecs.push_back(nu(32'h10, 1, 32'h40));
        vecs.push_back(up(32'h10, 1, 32'h10, 0, 0, 0, 1, 32'h40, 0, 1, 32'h40, 1, 32'h11));
        vecs.push_back(up(32'h10, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11));
        vecs.push_back(up(32'h10, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11));
        vecs.push_back(nu(32'h10, 0, 0));
        vecs.push_back(up(32'h00, 1, 32'h03, 0, 1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h80));
        vecs.push_back(up(32'h03, 1, 32'h13, 0, 1, 32'h90, 0, 0, 0, 1, 32'h80, 1, 32'h90));
        vecs.push_back(nu(32'h03, 0, 0));
        vecs.push_back(nu(32'h13, 1, 32'h90));
        vecs.push_back(up(32'h05, 1, 32'h05, 0, 1, 32'h55, 0, 0, 0, 0, 0, 1, 32'h55));
        vecs.push_back(up(32'h05, 1, 32'h05, 0, 0, 0, 1, 32'h55, 0, 1, 32'h55, 1, 32'h06));
        vecs.push_back(nu(32'h05, 0, 0));
        vecs.push_back(up(32'h07, 1, 32'h07, 1, 1, 32'h70, 0, 0, 0, 0, 0, 1, 32'h70));
        vecs.push_back(up(32'h07, 1, 32'h07, 0, 0, 0, 1, 32'h70, 0, 1, 32'h70, 1, 32'h08));
        vecs.push_back(nu(32'h07, 1, 32'h70));
        vecs.push_back(up(32'h07, 1, 32'h07, 0, 1, 32'h44, 1, 32'h40, 0, 1, 32'h70, 1, 32'h44));
        vecs.push_back(nu(32'h07, 1, 32'h44));
        vecs.push_back(up(32'h13, 1, 32'h09, 0, 1, 32'h99, 0, 0, 1, 1, 32'h90, 1, 32'h99));
        vecs.push_back(nu(32'h09, 0, 0));
        vecs.push_back(nu(32'h13, 0, 0));
        vecs.push_back(nu(32'h07, 0, 0));
        vecs.push_back(up(32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(up(32'h10, 0, 32'h20, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h21));

        rst_n = 1'b0;
        apply(nu(32'h10, 0, 0));
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.taken_F", pred_taken_F, 0);
        chk("reset.lookup_cnt", lookup_cnt, 0);
        chk("reset.mispredict_cnt", mispredict_cnt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(nu(32'h10, 0, 0), 1, "count");
        chk("count.lookup_cnt3", lookup_cnt, 3);

        foreach (vecs[i]) step(vecs[i], 1, $sformatf("vec%0d", i));

        // Random traffic on a small PC window so entries hit, alias and saturate.
        for (int n = 0; n < 300; n++) begin
            logic          tk;
            logic [PW-1:0] tg;
            v.pc_f = PW'($urandom_range(0, 47));
            v.uv   = ($urandom % 4) != 0;
            v.upc  = ($urandom % 20 == 0) ? 32'hFFFFFFFF : PW'($urandom_range(0, 47));
            v.ut   = $urandom % 2;
            v.uj   = v.ut && ($urandom % 5 == 0);
            v.utgt = PW'($urandom_range(0, 255));
            model_pred(v.upc, tk, tg);
            if ($urandom % 2) begin v.pte = tk; v.ptt = tg; end
            else begin v.pte = $urandom % 2; v.ptt = PW'($urandom_range(0, 255)); end
            v.clr  = ($urandom % 40) == 0;
            v.e_tk = 0; v.e_tg = 0; v.e_mis = 0; v.e_rd = 0;
            step(v, 0, "rand");
        end
        chk("sat.lookup_cnt", lookup_cnt, 255);

        // Asynchronous reset in mid-cycle with an update pending.
        step(up(32'h21, 1, 32'h21, 0, 1, 32'h2A, 0, 0, 0, 0, 0, 0, 0), 0, "pre_rst");
        apply(up(32'h21, 1, 32'h22, 0, 1, 32'h2B, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst.taken_F", pred_taken_F, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.taken_F", pred_taken_F, 0);
        chk("async_rst.lookup_cnt", lookup_cnt, 0);
        chk("async_rst.mispredict_cnt", mispredict_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(nu(32'h22, 0, 0), 1, "post_rst22");
        step(nu(32'h21, 0, 0), 1, "post_rst21");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
